yags_update_scheduler: RTL and testbench

Sequencing controller for the YAGS direction PHT write side. It accepts resolved-branch records from the execute stage and queues them in a small FIFO. It issues them to the PHT `update` / `miss_predict` port one per cycle, and clears the tag store after reset or flush with a sweep. It sits between the branch-resolution logic and `direction_PHT`. It owns every write-side PHT control signal, so the PHT sees at most one write per cycle and is never written while it is being initialised.

---
 rtl/yags_update_scheduler.sv | 166 ++++++++++++++++
 tb/tb_yags_update_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/yags_update_scheduler.sv
// Write-side sequencer for the YAGS direction PHT: queues resolved branches, issues one per cycle, sweeps the tag store clear.
// Optional macro YAGS_UPD_COALESCE_EN merges a record into a matching tail entry instead of enqueuing it.
module yags_update_scheduler #(
  parameter int PC_SIZE  = 10,
  parameter int GHR_SIZE = 10,
  parameter int DEPTH    = 64,
  parameter int QDEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic [PC_SIZE-1:0]          res_pc,
  input  logic [GHR_SIZE-1:0]         res_history,
  input  logic                        res_mispredict,
  input  logic [1:0]                  res_outcome,
  input  logic                        flush,
  input  logic                        hold,
  output logic                        pht_update,
  output logic                        pht_miss_predict,
  output logic [PC_SIZE-1:0]          pht_address,
  output logic [GHR_SIZE-1:0]         pht_history,
  output logic [1:0]                  pht_actual_prediction,
  output logic                        pht_clear,
  output logic [$clog2(DEPTH)-1:0]    pht_clear_index,
  output logic                        init_done,
  output logic [$clog2(QDEPTH):0]     occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(QDEPTH);
  localparam int OW = PW + 1;

  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

  state_t state, state_next;

  logic [PC_SIZE-1:0]  q_pc   [QDEPTH];
  logic [GHR_SIZE-1:0] q_hist [QDEPTH];
  logic                q_mp   [QDEPTH];
  logic [1:0]          q_out  [QDEPTH];
  logic [PW-1:0]       rd_ptr, wr_ptr;

  logic pop, accept, merge, push, sweep_last;

  assign res_ready  = (state == RUN) && (occupancy < OW'(QDEPTH));
  assign accept     = res_valid && res_ready && !flush;
  assign pop        = (state == RUN) && !flush && !hold && (occupancy != '0);
  assign sweep_last = pht_clear && (pht_clear_index == IW'(DEPTH - 1));

`ifdef YAGS_UPD_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr - PW'(1);
  // The tail may only absorb a record if it is not simultaneously leaving as the head.
  assign merge = accept && (occupancy != '0) && !(pop && occupancy == OW'(1)) &&
                 (q_pc[tail_ptr] == res_pc) && (q_hist[tail_ptr] == res_history);
`else
  assign merge = 1'b0;
`endif
  assign push = accept && !merge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (!flush && sweep_last) state_next = RUN;
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   state_next = INIT;
      default: state_next = INIT;
    endcase
  end

  // Clear sweep: the first pulse carries index 0, init_done follows the pulse for the last block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pht_clear       <= 1'b0;
      pht_clear_index <= '0;
      init_done       <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (flush) begin
            pht_clear       <= 1'b0;
            pht_clear_index <= '0;
          end else if (!pht_clear) begin
            pht_clear       <= 1'b1;
            pht_clear_index <= '0;
          end else if (sweep_last) begin
            pht_clear <= 1'b0;
            init_done <= 1'b1;
          end else begin
            pht_clear_index <= pht_clear_index + IW'(1);
          end
        end
        RUN: begin
          pht_clear <= 1'b0;
          if (flush) init_done <= 1'b0;
        end
        default: begin
          pht_clear       <= 1'b0;
          pht_clear_index <= '0;
          init_done       <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else if ((state == RUN && flush) || state == DRAIN) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= res_pc;
      q_hist[wr_ptr] <= res_history;
      q_mp[wr_ptr]   <= res_mispredict;
      q_out[wr_ptr]  <= res_outcome;
    end
`ifdef YAGS_UPD_COALESCE_EN
    else if (merge) begin
      q_out[tail_ptr] <= res_outcome;
      q_mp[tail_ptr]  <= q_mp[tail_ptr] | res_mispredict;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pht_update            <= 1'b0;
      pht_miss_predict      <= 1'b0;
      pht_address           <= '0;
      pht_history           <= '0;
      pht_actual_prediction <= '0;
    end else begin
      pht_update <= pop;
      if (pop) begin
        pht_miss_predict      <= q_mp[rd_ptr];
        pht_address           <= q_pc[rd_ptr];
        pht_history           <= q_hist[rd_ptr];
        pht_actual_prediction <= q_out[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_yags_update_scheduler.sv
// Self-checking bench for yags_update_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_yags_update_scheduler;

  localparam int DEPTH  = 64;
  localparam int QDEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       res_valid = 1'b0;
  logic       res_ready;
  logic [9:0] res_pc = '0;
  logic [9:0] res_history = '0;
  logic       res_mispredict = 1'b0;
  logic [1:0] res_outcome = '0;
  logic       flush = 1'b0;
  logic       hold = 1'b0;
  logic       pht_update, pht_miss_predict, pht_clear, init_done;
  logic [9:0] pht_address, pht_history;
  logic [1:0] pht_actual_prediction;
  logic [5:0] pht_clear_index;
  logic [2:0] occupancy;

  yags_update_scheduler #(.PC_SIZE(10), .GHR_SIZE(10), .DEPTH(DEPTH), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc), .res_history(res_history),
    .res_mispredict(res_mispredict), .res_outcome(res_outcome),
    .flush(flush), .hold(hold),
    .pht_update(pht_update), .pht_miss_predict(pht_miss_predict), .pht_address(pht_address),
    .pht_history(pht_history), .pht_actual_prediction(pht_actual_prediction),
    .pht_clear(pht_clear), .pht_clear_index(pht_clear_index),
    .init_done(init_done), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] pc;
    logic [9:0] hist;
    logic       mp;
    logic [1:0] out;
  } rec_t;

  // Model: sc counts edges since the sweep began (-1 while draining); past DEPTH the block is running.
  rec_t q[$];
  int   sc;
  logic m_upd;
  rec_t m_last;
  int   checks = 0;
  int   errors = 0;
  bit   last_acc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    sc = 0;
    m_upd = 1'b0;
    m_last.pc = '0; m_last.hist = '0; m_last.mp = 1'b0; m_last.out = '0;
  endtask

  task automatic checkAll();
    bit exp_clear;
    exp_clear = (sc >= 1) && (sc <= DEPTH);
    checkOutput("pht_clear", pht_clear, exp_clear);
    if (exp_clear) checkOutput("pht_clear_index", pht_clear_index, sc - 1);
    checkOutput("init_done", init_done, sc > DEPTH);
    checkOutput("pht_update", pht_update, m_upd);
    checkOutput("pht_address", pht_address, m_last.pc);
    checkOutput("pht_history", pht_history, m_last.hist);
    checkOutput("pht_miss_predict", pht_miss_predict, m_last.mp);
    checkOutput("pht_actual_prediction", pht_actual_prediction, m_last.out);
    checkOutput("occupancy", occupancy, q.size());
  endtask

  // One clock: drive inputs, check the handshake, advance the model at the edge, check registered outputs.
  task automatic applyStimulus(input bit v, input logic [9:0] pc, input logic [9:0] hist,
                               input bit mp, input logic [1:0] o, input bit h, input bit f);
    bit   exp_ready, acc, merged;
    rec_t r, t;
    res_valid = v; res_pc = pc; res_history = hist; res_mispredict = mp; res_outcome = o;
    hold = h; flush = f;
    #1;
    exp_ready = (sc > DEPTH) && (q.size() < QDEPTH);
    checkOutput("res_ready", res_ready, exp_ready);
    acc = v && exp_ready && !f;
    r.pc = pc; r.hist = hist; r.mp = mp; r.out = o;
    @(posedge clk);
    m_upd = 1'b0;
    if (sc > DEPTH) begin
      if (f) begin
        q.delete();
        sc = -1;
      end else begin
        if (q.size() > 0 && !h) begin
          m_last = q.pop_front();
          m_upd = 1'b1;
        end
        if (acc) begin
          merged = 1'b0;
`ifdef YAGS_UPD_COALESCE_EN
          if (q.size() > 0 && q[q.size()-1].pc == pc && q[q.size()-1].hist == hist) begin
            t = q[q.size()-1];
            t.out = o;
            t.mp = t.mp | mp;
            q[q.size()-1] = t;
            merged = 1'b1;
          end
`endif
          if (!merged) q.push_back(r);
        end
      end
    end else if (sc < 0) begin
      sc = 0;
    end else begin
      sc = f ? 0 : sc + 1;
    end
    last_acc = acc;
    #1;
    checkAll();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_res_ready", res_ready, 0);
    checkOutput("rst_clear_index", pht_clear_index, 0);
    checkAll();
  endtask

  initial begin
    int   n;
    rec_t recs[5];
    logic [9:0] pcs[4];
    pcs[0] = 10'h011; pcs[1] = 10'h2A0; pcs[2] = 10'h3FF; pcs[3] = 10'h155;
    modelReset();
    #12;
    checkResetValues();
    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep after reset release, then idle RUN.
    idle(DEPTH + 3);

    // Single record issued one cycle after acceptance.
    applyStimulus(1'b1, 10'h1A4, 10'h3C5, 1'b1, 2'b11, 1'b0, 1'b0);
    idle(3);

    // Five records against a held queue, then release.
    for (int i = 0; i < 5; i++) begin
      recs[i].pc = 10'h100 + 10'(i); recs[i].hist = 10'h050 + 10'(3 * i);
      recs[i].mp = i[0]; recs[i].out = i[1] ? 2'b11 : 2'b00;
    end
    n = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, recs[n].pc, recs[n].hist, recs[n].mp, recs[n].out, 1'b1, 1'b0);
      if (last_acc) n++;
    end
    checkOutput("hold_accepted", n, 4);
    for (int c = 0; c < 8 && n < 5; c++) begin
      applyStimulus(1'b1, recs[n].pc, recs[n].hist, recs[n].mp, recs[n].out, 1'b0, 1'b0);
      if (last_acc) n++;
    end
    checkOutput("fifth_accepted", n, 5);
    idle(6);

    // Flush with three queued entries, then a fresh sweep.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, recs[i].pc, recs[i].hist, recs[i].mp, recs[i].out, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 2'b00, 1'b1, 1'b1);
    idle(DEPTH + 4);

    // Same pc/history twice while held.
    applyStimulus(1'b1, 10'h0F0, 10'h123, 1'b0, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'h0F0, 10'h123, 1'b1, 2'b11, 1'b1, 1'b0);
    idle(4);

    // Asynchronous reset in the middle of RUN with two entries queued.
    applyStimulus(1'b1, 10'h201, 10'h002, 1'b1, 2'b11, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'h202, 10'h003, 1'b0, 2'b00, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkResetValues();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    // Flush in the middle of the sweep restarts it.
    applyStimulus(1'b0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b1);
    idle(DEPTH + 3);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 9) < 7, pcs[$urandom_range(0, 3)], 10'h080 + 10'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 1) ? 2'b11 : 2'b00,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
